// File: rtl/wb_arb_2m1s.sv
// wb_arb_2m1s: two-master, one-slave Wishbone classic arbiter with bus timeout.
// Latency: a grant registers one cycle after cyc is raised; routing and response gating are combinational from the grant.
// Backpressure: the grant is held while the granted master keeps cyc high, and the other master waits.
//
// Ports:
//   clk_i, rst_i           clock; asynchronous active-high reset
//   m0_*                   instruction master: cyc/stb/we/sel/adr/dat in, dat/ack/err out
//   m1_*                   data master: same set of signals as m0
//   s_*                    shared slave: cyc/stb/we/sel/adr/dat out, dat/ack/err in
//   gnt_o                  one-hot grant status (bit0 = m0, bit1 = m1)
module wb_arb_2m1s #(
  parameter int PRIO_MODE = 0,    // 0 = round-robin, 1 = fixed priority, m1 wins
  parameter int TIMEOUT   = 255,  // unanswered-strobe cycles before a forced error; 0 = off
  parameter int TO_W      = 8     // timeout counter width, TIMEOUT < 2**TO_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0 (instruction)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1 (data)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  // status
  output logic [1:0]  gnt_o
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] G0   = 2'b01;
  localparam logic [1:0] G1   = 2'b10;

  logic [1:0] gnt_q, gnt_d;
  logic       last_m1_q;   // 1 when m1 received the most recent grant
  logic       to_err_q;    // forced timeout error, high for one cycle
  logic       to_wait;     // slave strobed and has not answered this cycle

  // Next-grant selection. Leaving a grant hands the bus straight to the other
  // master if it is requesting, so back-to-back cycles see no idle gap.
  always_comb begin
    gnt_d = gnt_q;
    case (gnt_q)
      G0: if (!m0_cyc_i) gnt_d = m1_cyc_i ? G1 : IDLE;
      G1: if (!m1_cyc_i) gnt_d = m0_cyc_i ? G0 : IDLE;
      default: begin
        if (m0_cyc_i && m1_cyc_i)
          gnt_d = ((PRIO_MODE != 0) || !last_m1_q) ? G1 : G0;
        else if (m0_cyc_i)
          gnt_d = G0;
        else if (m1_cyc_i)
          gnt_d = G1;
        else
          gnt_d = IDLE;
      end
    endcase
  end

  // The pointer resets to m1 so that m0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q     <= IDLE;
      last_m1_q <= 1'b1;
    end else begin
      gnt_q <= gnt_d;
      if (gnt_d != gnt_q && gnt_d != IDLE)
        last_m1_q <= gnt_d[1];
    end
  end

  // Slave-side routing. The strobe is withheld during the forced-error cycle so
  // the slave never sees a transfer that the master is told has failed.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (gnt_q)
      G0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~to_err_q;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      G1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~to_err_q;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign to_wait = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
      logic [TO_W-1:0] to_cnt_q;

      // A grant change needs the granted master's cyc low, which already
      // breaks to_wait, so the counter restarts for every new owner.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          to_cnt_q <= '0;
          to_err_q <= 1'b0;
        end else if (to_wait) begin
          if (to_cnt_q == TO_LAST) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            to_err_q <= 1'b0;
          end
        end else begin
          to_cnt_q <= '0;
          to_err_q <= 1'b0;
        end
      end
    end else begin : g_no_timeout
      assign to_err_q = 1'b0;
    end
  endgenerate

  // Responses reach only the granted master, and only while it still strobes,
  // so a late ack after the master gave up is dropped.
  assign m0_ack_o = s_ack_i & gnt_q[0] & m0_cyc_i & m0_stb_i;
  assign m1_ack_o = s_ack_i & gnt_q[1] & m1_cyc_i & m1_stb_i;
  assign m0_err_o = (s_err_i & gnt_q[0] & m0_cyc_i & m0_stb_i) | (to_err_q & gnt_q[0]);
  assign m1_err_o = (s_err_i & gnt_q[1] & m1_cyc_i & m1_stb_i) | (to_err_q & gnt_q[1]);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_wb_arb_2m1s.sv
// tb_wb_arb_2m1s: directed bench for the two-master Wishbone arbiter.
// Instance a: round-robin with a 4-cycle timeout; instance b: fixed priority, timeout off.
// Both instances share all inputs; b is only checked in the priority section.
module tb_wb_arb_2m1s;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 0, s_err_i = 0;

  // instance a outputs
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;
  // instance b outputs
  logic [31:0] b_m0_dat_o, b_m1_dat_o, b_s_adr_o, b_s_dat_o;
  logic        b_m0_ack_o, b_m0_err_o, b_m1_ack_o, b_m1_err_o;
  logic        b_s_cyc_o, b_s_stb_o, b_s_we_o;
  logic [3:0]  b_s_sel_o;
  logic [1:0]  b_gnt_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  wb_arb_2m1s #(.PRIO_MODE(0), .TIMEOUT(4), .TO_W(8)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  wb_arb_2m1s #(.PRIO_MODE(1), .TIMEOUT(0), .TO_W(8)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(b_m0_dat_o), .m0_ack_o(b_m0_ack_o), .m0_err_o(b_m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(b_m1_dat_o), .m1_ack_o(b_m1_ack_o), .m1_err_o(b_m1_err_o),
    .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o), .s_we_o(b_s_we_o), .s_sel_o(b_s_sel_o),
    .s_adr_o(b_s_adr_o), .s_dat_o(b_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(b_gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    // ---------------- reset state ----------------
    s_dat_i = 32'h0000_A5A5;
    #3;
    chk("rst_gnt",     32'(gnt_o), 32'h0);
    chk("rst_s_cyc",   32'(s_cyc_o), 32'h0);
    chk("rst_s_adr",   s_adr_o, 32'h0);
    chk("rst_m0_ack",  32'(m0_ack_o), 32'h0);
    chk("rst_m1_err",  32'(m1_err_o), 32'h0);
    chk("rst_m0_dat",  m0_dat_o, 32'h0000_A5A5);
    chk("rst_m1_dat",  m1_dat_o, 32'h0000_A5A5);
    step();
    rst_i = 1'b0;
    step();

    // ---------------- single m0 read ----------------
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    #1;
    chk("rd_gnt_pre",  32'(gnt_o), 32'h0);
    chk("rd_scyc_pre", 32'(s_cyc_o), 32'h0);
    step();
    chk("rd_gnt",      32'(gnt_o), 32'h1);
    chk("rd_s_adr",    s_adr_o, 32'h100);
    chk("rd_s_stb",    32'(s_stb_o), 32'h1);
    chk("rd_ack_early",32'(m0_ack_o), 32'h0);
    step();
    step();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_ack",   32'(m0_ack_o), 32'h1);
    chk("rd_m0_dat",   m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m1_ack",   32'(m1_ack_o), 32'h0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("rd_ack_once", 32'(m0_ack_o), 32'h0);
    chk("rd_gnt_hold", 32'(gnt_o), 32'h1);
    step();
    chk("rd_gnt_idle", 32'(gnt_o), 32'h0);

    // ---------------- round-robin after reset ----------------
    #1 rst_i = 1'b1;
    #1 rst_i = 1'b0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
    step();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d_gnt", k), 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr%0d_adr", k), s_adr_o, (k % 2 == 0) ? 32'h10 : 32'h20);
      s_ack_i = 1;
      #1;
      chk($sformatf("rr%0d_ack0", k), 32'(m0_ack_o), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d_ack1", k), 32'(m1_ack_o), (k % 2 == 0) ? 32'h0 : 32'h1);
      step();
      s_ack_i = 0;
      if (k % 2 == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
      else            begin m1_cyc_i = 0; m1_stb_i = 0; end
      step();
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    end
    #1;
    chk("rr_final_gnt", 32'(gnt_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("rr_idle", 32'(gnt_o), 32'h0);

    // ---------------- fixed priority (instance b) ----------------
    chk("pr_idle", 32'(b_gnt_o), 32'h0);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    chk("pr_m1_first", 32'(b_gnt_o), 32'h2);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("pr_m0_when_m1_low", 32'(b_gnt_o), 32'h1);
    m1_cyc_i = 1; m1_stb_i = 1; m0_cyc_i = 0; m0_stb_i = 0;
    step();
    chk("pr_back_to_m1", 32'(b_gnt_o), 32'h2);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    chk("pr_idle2", 32'(b_gnt_o), 32'h0);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    chk("pr_m1_again", 32'(b_gnt_o), 32'h2);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    step();
    chk("pr_a_idle", 32'(gnt_o), 32'h0);

    // ---------------- m1 write ----------------
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'h3;
    m1_adr_i = 32'h2000_0004; m1_dat_i = 32'h0000_1234;
    step();
    chk("wr_gnt",   32'(gnt_o), 32'h2);
    chk("wr_we",    32'(s_we_o), 32'h1);
    chk("wr_sel",   32'(s_sel_o), 32'h3);
    chk("wr_adr",   s_adr_o, 32'h2000_0004);
    chk("wr_dat",   s_dat_o, 32'h0000_1234);
    chk("wr_noack", 32'(m1_ack_o), 32'h0);
    s_ack_i = 1;
    #1;
    chk("wr_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("wr_m0_ack", 32'(m0_ack_o), 32'h0);
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0;
    step();
    chk("wr_idle", 32'(gnt_o), 32'h0);

    // ---------------- timeout (TIMEOUT = 4) ----------------
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h300;
    step();
    chk("to_stb_rise", 32'(s_stb_o), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("to_noerr%0d", c), 32'(m0_err_o), 32'h0);
    end
    step();
    chk("to_err",     32'(m0_err_o), 32'h1);
    chk("to_stb_low", 32'(s_stb_o), 32'h0);
    chk("to_m1_err",  32'(m1_err_o), 32'h0);
    chk("to_b_off",   32'(b_m0_err_o), 32'h0);
    step();
    chk("to_err_1cyc", 32'(m0_err_o), 32'h0);
    chk("to_stb_back", 32'(s_stb_o), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("to_re_noerr%0d", c), 32'(m0_err_o), 32'h0);
    end
    step();
    chk("to_err_again", 32'(m0_err_o), 32'h1);
    step();
    m0_stb_i = 0; s_ack_i = 1;
    #1;
    chk("to_late_ack", 32'(m0_ack_o), 32'h0);
    step();
    s_ack_i = 0; m0_cyc_i = 0;
    step();
    chk("to_idle", 32'(gnt_o), 32'h0);

    // ---------------- reset while G1 waits ----------------
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h400;
    step();
    chk("rm_gnt", 32'(gnt_o), 32'h2);
    step();
    m0_cyc_i = 1; m0_stb_i = 1;
    rst_i = 1; s_ack_i = 1;
    #1;
    chk("rm_gnt_clr", 32'(gnt_o), 32'h0);
    chk("rm_s_cyc",   32'(s_cyc_o), 32'h0);
    chk("rm_s_stb",   32'(s_stb_o), 32'h0);
    chk("rm_m1_ack",  32'(m1_ack_o), 32'h0);
    chk("rm_m1_err",  32'(m1_err_o), 32'h0);
    s_ack_i = 0;
    #1 rst_i = 0;
    step();
    chk("rm_m0_first", 32'(gnt_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_arb_2m1s.md
Name: wb_arb_2m1s

Overview:
- Two-master to one-slave Wishbone classic arbiter.
- Sits directly downstream of the RISC-V Wishbone bridge: m0 is the instruction master port, m1 is the data master port, and s is the shared slave bus to memory/peripherals.
- Selects one master per bus cycle and holds the grant until that master drops cyc.
- Routes the granted master's signals to the slave and returns ack/err/data only to the granted master.
- Generates a bus-error response when the slave does not respond in time.

Parameters:
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with m1 (data) winning.
- TIMEOUT, 255, cycles of unanswered s_stb before an error is forced; 0 disables the timeout.
- TO_W, 8, timeout counter width; requires TIMEOUT < 2**TO_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (instruction) cycle, strobe, write enable
- m0_sel_i  in  4  master 0 byte selects
- m0_adr_i, m0_dat_i  in  32 each  master 0 address, write data
- m0_dat_o  out  32  master 0 read data
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge, error
- m1_*  same set as m0_*  master 1 (data)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable
- s_sel_o  out  4  slave byte selects
- s_adr_o, s_dat_o  out  32 each  slave address, write data
- s_dat_i  in  32  slave read data
- s_ack_i, s_err_i  in  1 each  slave acknowledge, error
- gnt_o  out  2  one-hot grant status: bit0 = m0, bit1 = m1

Behaviour:
- State is the registered grant: IDLE (gnt=00), G0 (01), G1 (10). No other encodings are reachable.
- Reset: gnt=00, last-granted pointer = m1 (so m0 wins the first tie), timeout counter = 0, forced-error flag = 0.
  - All s_* outputs are 0 while gnt=00.
  - m*_ack_o, m*_err_o = 0.
  - m*_dat_o = s_dat_i, broadcast combinationally to both masters at all times.
- IDLE:
  - Only m0_cyc_i high -> G0. Only m1_cyc_i high -> G1. Neither high -> stay IDLE.
  - Both high, PRIO_MODE=0: grant the master that is not the last-granted one.
  - Both high, PRIO_MODE=1: grant m1.
  - The grant takes effect at the next edge. Slave signals therefore appear one cycle after the master raises cyc.
- G0/G1:
  - Hold the grant while the granted master's cyc is high.
  - When the granted master's cyc is low at an edge, re-arbitrate in that same edge: the other master goes directly to its grant if requesting, else IDLE.
  - The pointer updates on every new grant.
- Routing while granted (combinational from gnt):
  - s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o = the granted master's inputs.
  - s_stb_o is additionally forced 0 in the cycle a timeout error is being returned.
- Response gating:
  - mX_ack_o = s_ack_i & gntX & mX_cyc_i & mX_stb_i.
  - mX_err_o = (s_err_i & the same gating) | forced-error flag for gntX.
  - The non-granted master never sees ack or err.
  - If s_ack_i and s_err_i are both high, both are passed through.
- Timeout (TIMEOUT>0):
  - The counter increments each cycle with s_cyc_o & s_stb_o & !s_ack_i & !s_err_i.
  - It clears on ack, err, grant change, or stb low.
  - When the counter == TIMEOUT-1 at an edge, set the forced-error flag for exactly one cycle and clear the counter.
  - A slave ack that arrives late is gated off if the master has already dropped stb.
- Reset mid-transaction: grant, counter and flag clear immediately (asynchronously) and all s_* go to 0 the same instant. No ack or err is generated.
- No combinational path from s_ack_i to any s_* output.

Test Plan:
- Single m0 read: m0 cyc/stb high with adr=0x100; slave acks with dat=0xDEADBEEF 2 cycles after s_stb -> gnt_o=01 one cycle after request, s_adr_o=0x100, m0_ack_o 1 cycle, m0_dat_o=0xDEADBEEF, m1_ack_o=0; gnt_o returns to 00 after m0 drops cyc.
- Simultaneous requests after reset, PRIO_MODE=0, both masters hold cyc through their ack -> m0 granted first, m1 granted at the edge m0 drops cyc with no IDLE cycle, then m0 again; strict alternation over 8 transactions.
- PRIO_MODE=1, both requesting continuously -> m1 always wins in IDLE; m0 granted only when m1_cyc_i is low.
- m1 write: we=1, sel=0x3, adr=0x2000_0004, dat=0x1234 -> s_we_o=1, s_sel_o=0x3, s_dat_o=0x1234; m1_ack_o pulses on s_ack_i.
- Timeout, TIMEOUT=4, slave never acks -> m0_err_o high exactly 4 cycles after s_stb_o first rises; s_stb_o low in that cycle; counter restarts if the master keeps stb high.
- Assert rst_i while G1 is waiting for ack -> gnt_o=00 and s_cyc_o=0 immediately; no m1_ack_o/m1_err_o; after release, a pending m0 request is granted first.
